// File: rtl/ysyx_22040365_ifu.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22040365_ifu
// Description : Instruction fetch unit. Holds the PC, issues one fetch request
//               at a time to instruction memory (valid/ready request channel,
//               in-order valid-only response channel), and hands the fetched
//               instruction plus its PC to decode under valid/ready. A redirect
//               from execute replaces the PC and squashes any instruction or
//               response that belongs to the old path.
//               Optional build macro YSYX_22040365_IFU_PERF_EN adds the
//               perf_fetch_cnt / perf_stall_cnt counter outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_22040365_ifu #(
    parameter int                 ADDR_W   = 64,
    parameter int                 INST_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = 64'h8000_0000
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc
`ifdef YSYX_22040365_IFU_PERF_EN
    ,
    output logic [63:0]       perf_fetch_cnt,
    output logic [63:0]       perf_stall_cnt
`endif
);

    localparam logic [ADDR_W-1:0] c_PC_STEP = ADDR_W'(4);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_HOLD = 3'd3,
        ST_DROP = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nx;
    logic [ADDR_W-1:0]   r_pc;
    logic [ADDR_W-1:0]   w_pc_nx;
    logic [INST_W-1:0]   r_inst;
    logic [INST_W-1:0]   w_inst_nx;
    logic [ADDR_W-1:0]   r_inst_pc;
    logic [ADDR_W-1:0]   w_inst_pc_nx;
    logic                r_inst_valid;
    logic                w_inst_valid_nx;

    // Redirect targets are always word aligned; the low two bits are dropped.
    logic [ADDR_W-1:0]   w_redirect_tgt;
    logic                w_unused_redirect_lsbs;

    assign w_redirect_tgt         = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign w_unused_redirect_lsbs = &{1'b0, redirect_pc[1:0]};

    // Request is only presented in REQ, so at most one fetch is ever in flight.
    assign imem_req_valid = (r_state == ST_REQ);
    assign imem_req_addr  = r_pc;
    assign inst_valid     = r_inst_valid;
    assign inst           = r_inst;
    assign inst_pc        = r_inst_pc;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_pc         <= RESET_PC;
            r_inst       <= '0;
            r_inst_pc    <= RESET_PC;
            r_inst_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_pc         <= w_pc_nx;
            r_inst       <= w_inst_nx;
            r_inst_pc    <= w_inst_pc_nx;
            r_inst_valid <= w_inst_valid_nx;
        end
    end

    // Next-state and datapath update; a redirect wins over every other event.
    always_comb begin
        w_state_nx      = r_state;
        w_pc_nx         = r_pc;
        w_inst_nx       = r_inst;
        w_inst_pc_nx    = r_inst_pc;
        w_inst_valid_nx = r_inst_valid;

        case (r_state)
            ST_IDLE: begin
                w_state_nx = ST_REQ;
                if (redirect_valid) begin
                    w_pc_nx         = w_redirect_tgt;
                    w_inst_valid_nx = 1'b0;
                end
            end

            ST_REQ: begin
                if (redirect_valid) begin
                    w_pc_nx         = w_redirect_tgt;
                    w_inst_valid_nx = 1'b0;
                    // An accepted request still owes a response that must be eaten.
                    w_state_nx      = imem_req_ready ? ST_DROP : ST_REQ;
                end else if (imem_req_ready) begin
                    w_state_nx = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (redirect_valid) begin
                    w_pc_nx         = w_redirect_tgt;
                    w_inst_valid_nx = 1'b0;
                    // A response landing this same cycle is simply discarded.
                    w_state_nx      = imem_rsp_valid ? ST_REQ : ST_DROP;
                end else if (imem_rsp_valid) begin
                    w_inst_nx       = imem_rsp_data;
                    w_inst_pc_nx    = r_pc;
                    w_inst_valid_nx = 1'b1;
                    w_state_nx      = ST_HOLD;
                end
            end

            ST_HOLD: begin
                if (redirect_valid) begin
                    // Squash even when decode is accepting in the same cycle.
                    w_pc_nx         = w_redirect_tgt;
                    w_inst_valid_nx = 1'b0;
                    w_state_nx      = ST_REQ;
                end else if (inst_ready) begin
                    w_pc_nx         = r_pc + c_PC_STEP;
                    w_inst_valid_nx = 1'b0;
                    w_state_nx      = ST_REQ;
                end
            end

            ST_DROP: begin
                if (redirect_valid) begin
                    w_pc_nx         = w_redirect_tgt;
                    w_inst_valid_nx = 1'b0;
                end else if (imem_rsp_valid) begin
                    w_state_nx = ST_REQ;
                end
            end

            default: begin
                w_state_nx      = ST_IDLE;
                w_inst_valid_nx = 1'b0;
            end
        endcase
    end

`ifdef YSYX_22040365_IFU_PERF_EN
    logic [63:0] r_perf_fetch_cnt;
    logic [63:0] r_perf_stall_cnt;
    logic        w_fetch_hit;
    logic        w_stall_hit;

    assign w_fetch_hit    = r_inst_valid && inst_ready && !redirect_valid;
    assign w_stall_hit    = ((r_state == ST_REQ) && !imem_req_ready) || (r_state == ST_WAIT);
    assign perf_fetch_cnt = r_perf_fetch_cnt;
    assign perf_stall_cnt = r_perf_stall_cnt;

    // Delivered-instruction and memory-stall counters, free-running with wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perf_fetch_cnt <= 64'd0;
            r_perf_stall_cnt <= 64'd0;
        end else begin
            if (w_fetch_hit) begin
                r_perf_fetch_cnt <= r_perf_fetch_cnt + 64'd1;
            end
            if (w_stall_hit) begin
                r_perf_stall_cnt <= r_perf_stall_cnt + 64'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22040365_ifu.sv
`default_nettype none
// ============================================================================
// Module      : tb_ysyx_22040365_ifu
// Description : Self-checking bench for the instruction fetch unit. A table of
//               fetch scenarios (stall lengths, response latency, expected
//               address) drives the main path; hand-written sequences cover
//               redirects, PC wrap and reset during a fetch. Expected
//               instructions are queued when a request is accepted and popped
//               when the unit presents them to decode.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_22040365_ifu;

    localparam logic [63:0] c_RESET_PC = 64'h8000_0000;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        redirect_valid;
    logic [63:0] redirect_pc;

    ysyx_22040365_ifu #(
        .ADDR_W   (64),
        .INST_W   (32),
        .RESET_PC (c_RESET_PC)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    typedef struct {
        logic [63:0] pc;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        int          rq;    // cycles with req_ready low before acceptance
        int          lat;   // response latency in cycles after acceptance (>=1)
        int          hold;  // cycles with inst_ready low while holding
        logic [63:0] addr;  // expected fetch address
    } vec_t;

    exp_t sb[$];
    vec_t tbl[6];
    int   n_chk;
    int   n_fail;
    int   cyc;
    int   valid_cyc;
    int   prev_valid_cyc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mdata(input logic [63:0] a);
        return a[31:0] ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // One complete fetch starting with the unit in REQ at exp_addr.
    task automatic fetch_one(input int rq_stall, input int rsp_lat, input int hold_stall,
                             input logic [63:0] exp_addr);
        int   bad;
        exp_t e;
        chk("req_valid", 64'(imem_req_valid), 64'd1);
        chk("req_addr", imem_req_addr, exp_addr);
        bad = 0;
        imem_req_ready = 1'b0;
        for (int k = 0; k < rq_stall; k++) begin
            step();
            if (!imem_req_valid || imem_req_addr !== exp_addr || inst_valid) bad++;
        end
        if (rq_stall > 0) chk("req_stall_stable", 64'(bad), 64'd0);
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        sb.push_back('{pc: exp_addr, data: mdata(exp_addr)});
        chk("wait_no_req", 64'(imem_req_valid), 64'd0);
        bad = 0;
        for (int k = 1; k < rsp_lat; k++) begin
            step();
            if (imem_req_valid || inst_valid) bad++;
        end
        if (rsp_lat > 1) chk("wait_quiet", 64'(bad), 64'd0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mdata(exp_addr);
        step();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
        valid_cyc = cyc;
        chk("inst_valid_rise", 64'(inst_valid), 64'd1);
        chk("sb_depth", 64'(sb.size()), 64'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("inst", 64'(inst), 64'(e.data));
            chk("inst_pc", inst_pc, e.pc);
        end else begin
            e = '{pc: exp_addr, data: mdata(exp_addr)};
        end
        bad = 0;
        inst_ready = 1'b0;
        for (int k = 0; k < hold_stall; k++) begin
            step();
            if (inst !== e.data || inst_pc !== e.pc || !inst_valid || imem_req_valid) bad++;
        end
        if (hold_stall > 0) chk("hold_stable", 64'(bad), 64'd0);
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        chk("inst_consumed", 64'(inst_valid), 64'd0);
        chk("next_addr", imem_req_addr, exp_addr + 64'd4);
    endtask

    initial begin
        n_chk = 0; n_fail = 0; cyc = 0; valid_cyc = 0; prev_valid_cyc = 0;
        tbl[0] = '{rq: 0, lat: 1, hold: 0, addr: 64'h8000_0000};
        tbl[1] = '{rq: 0, lat: 1, hold: 0, addr: 64'h8000_0004};
        tbl[2] = '{rq: 0, lat: 1, hold: 0, addr: 64'h8000_0008};
        tbl[3] = '{rq: 0, lat: 1, hold: 5, addr: 64'h8000_000C};
        tbl[4] = '{rq: 4, lat: 1, hold: 0, addr: 64'h8000_0010};
        tbl[5] = '{rq: 2, lat: 3, hold: 1, addr: 64'h8000_0014};

        rst = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;

        // Reset state
        step(); step();
        chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
        chk("rst_req_addr", imem_req_addr, c_RESET_PC);
        chk("rst_inst_valid", 64'(inst_valid), 64'd0);
        chk("rst_inst", 64'(inst), 64'd0);
        chk("rst_inst_pc", inst_pc, c_RESET_PC);
        rst = 1'b1;
        step();

        // Table-driven fetch scenarios
        for (int i = 0; i < 6; i++) begin
            prev_valid_cyc = valid_cyc;
            fetch_one(tbl[i].rq, tbl[i].lat, tbl[i].hold, tbl[i].addr);
            if (i > 0 && tbl[i].rq == 0 && tbl[i].lat == 1 && tbl[i-1].hold == 0)
                chk("fetch_spacing", 64'(valid_cyc - prev_valid_cyc), 64'd3);
        end

        // Redirect while waiting: late response is dropped, target aligned
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        sb.push_back('{pc: 64'h8000_0018, data: mdata(64'h8000_0018)});
        redirect_valid = 1'b1; redirect_pc = 64'h8000_0103;
        step();
        redirect_valid = 1'b0;
        sb.delete();
        chk("drop_no_req", 64'(imem_req_valid), 64'd0);
        chk("drop_no_inst", 64'(inst_valid), 64'd0);
        imem_rsp_valid = 1'b1; imem_rsp_data = mdata(64'h8000_0018);
        step();
        imem_rsp_valid = 1'b0;
        chk("drop_discard", 64'(inst_valid), 64'd0);
        fetch_one(0, 1, 0, 64'h8000_0100);

        // Redirect in HOLD with decode accepting; target at top of address space
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1; imem_rsp_data = mdata(64'h8000_0104);
        step();
        imem_rsp_valid = 1'b0;
        chk("hold_pc", inst_pc, 64'h8000_0104);
        inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        inst_ready = 1'b0; redirect_valid = 1'b0;
        chk("hold_redir_squash", 64'(inst_valid), 64'd0);
        fetch_one(0, 1, 0, 64'hFFFF_FFFF_FFFF_FFFC);

        // Redirect in WAIT coinciding with the response
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1; imem_rsp_data = mdata(64'd0);
        redirect_valid = 1'b1; redirect_pc = 64'h40;
        step();
        imem_rsp_valid = 1'b0; redirect_valid = 1'b0;
        chk("wait_rsp_redir_inst", 64'(inst_valid), 64'd0);
        chk("wait_rsp_redir_req", 64'(imem_req_valid), 64'd1);
        chk("wait_rsp_redir_addr", imem_req_addr, 64'h40);

        // Redirect in REQ while the request is being accepted
        imem_req_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h83;
        step();
        imem_req_ready = 1'b0; redirect_valid = 1'b0;
        chk("req_acc_redir_drop", 64'(imem_req_valid), 64'd0);
        imem_rsp_valid = 1'b1; imem_rsp_data = mdata(64'h40);
        step();
        imem_rsp_valid = 1'b0;
        chk("req_acc_redir_inst", 64'(inst_valid), 64'd0);
        chk("req_acc_redir_addr", imem_req_addr, 64'h80);

        // Reset in the middle of a fetch
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        rst = 1'b0;
        #1;
        chk("arst_req_valid", 64'(imem_req_valid), 64'd0);
        chk("arst_req_addr", imem_req_addr, c_RESET_PC);
        chk("arst_inst_valid", 64'(inst_valid), 64'd0);
        chk("arst_inst", 64'(inst), 64'd0);
        chk("arst_inst_pc", inst_pc, c_RESET_PC);
        sb.delete();
        step();
        rst = 1'b1;
        step();
        fetch_one(0, 1, 0, c_RESET_PC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
